// File: rtl/picosoc_iomem_fabric_if.sv
// CPU-side native memory bus and the shared peripheral-side bus of the iomem fabric.
interface picosoc_iomem_fabric_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  output mem_ready, mem_rdata);
endinterface

interface picosoc_iomem_slv_if #(
  parameter int unsigned NSLAVES = 4
);
  logic [NSLAVES-1:0]    s_valid;
  logic [NSLAVES-1:0]    s_ready;
  logic [31:0]           s_addr;
  logic [31:0]           s_wdata;
  logic [3:0]            s_wstrb;
  logic [NSLAVES*32-1:0] s_rdata;

  modport master (output s_valid, s_addr, s_wdata, s_wstrb,
                  input  s_ready, s_rdata);
  modport slave  (input  s_valid, s_addr, s_wdata, s_wstrb,
                  output s_ready, s_rdata);
endinterface

// File: rtl/picosoc_iomem_fabric.sv
// Windowed iomem interconnect: picorv32 native port to NSLAVES registered slave handshakes with
// first-error latch. Define PICOSOC_FABRIC_TIMEOUT_EN to build the ACCESS timeout counter.
module picosoc_iomem_fabric #(
  parameter int unsigned           NSLAVES   = 4,
  parameter logic [NSLAVES*32-1:0] SLV_BASE  = {NSLAVES{32'h0300_0000}},
  parameter logic [NSLAVES*32-1:0] SLV_MASK  = {NSLAVES{32'hFFFF_0000}},
  parameter int unsigned           TIMEOUT   = 255,
  parameter logic [31:0]           ERR_RDATA = 32'hBADB_ADDD
) (
  input  logic                  clk,
  input  logic                  resetn,
  picosoc_iomem_fabric_if.slave mbus,
  picosoc_iomem_slv_if.master   sbus,
  output logic                  err_irq,
  output logic [31:0]           err_addr,
  output logic [1:0]            err_code,
  input  logic                  err_clr
);
  localparam int unsigned SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  if (NSLAVES < 1 || NSLAVES > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("picosoc_iomem_fabric: NSLAVES or TIMEOUT out of range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;

  state_e             state_q, state_d;
  logic [SW-1:0]      sel_q, sel_d;
  logic [NSLAVES-1:0] s_valid_q, s_valid_d;
  logic               mem_ready_q, mem_ready_d;
  logic [31:0]        mem_rdata_q, mem_rdata_d;
  logic [31:0]        s_addr_q, s_addr_d;
  logic [31:0]        s_wdata_q, s_wdata_d;
  logic [3:0]         s_wstrb_q, s_wstrb_d;
  logic               err_irq_q, err_irq_d;
  logic [31:0]        err_addr_q, err_addr_d;
  logic [1:0]         err_code_q, err_code_d;

  logic [NSLAVES-1:0] hit;
  logic               hit_any;
  logic [SW-1:0]      hit_idx;
  logic               ack;
  logic               tmo;
  logic [31:0]        sel_rdata;
  logic               err_ev;
  logic [1:0]         err_ev_code;
  logic [31:0]        err_ev_addr;

  for (genvar gi = 0; gi < NSLAVES; gi++) begin : g_hit
    assign hit[gi] = (mbus.mem_addr & SLV_MASK[32*gi +: 32]) ==
                     (SLV_BASE[32*gi +: 32] & SLV_MASK[32*gi +: 32]);
  end

  // Scanning downwards leaves the lowest matching index, so overlaps resolve to the lower slave.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = int'(NSLAVES) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  assign ack       = (state_q == ST_ACCESS) && sbus.s_ready[sel_q];
  assign sel_rdata = sbus.s_rdata[{sel_q, 5'd0} +: 32];

`ifdef PICOSOC_FABRIC_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign tmo   = (state_q == ST_ACCESS) && !ack && (cnt_q == 16'(TIMEOUT));
  assign cnt_d = (state_q != ST_ACCESS) ? 16'd0 :
                 (ack || tmo)           ? cnt_q : cnt_q + 16'd1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    s_valid_d   = s_valid_q;
    mem_ready_d = 1'b0;
    mem_rdata_d = mem_rdata_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    s_wstrb_d   = s_wstrb_q;
    err_ev      = 1'b0;
    err_ev_code = 2'd0;
    err_ev_addr = s_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (mbus.mem_valid && !mem_ready_q) begin
          s_addr_d  = mbus.mem_addr;
          s_wdata_d = mbus.mem_wdata;
          s_wstrb_d = mbus.mem_wstrb;
          if (hit_any) begin
            sel_d              = hit_idx;
            s_valid_d          = '0;
            s_valid_d[hit_idx] = 1'b1;
            state_d            = ST_ACCESS;
          end else begin
            mem_ready_d = 1'b1;
            mem_rdata_d = ERR_RDATA;
            err_ev      = 1'b1;
            err_ev_code = 2'd1;
            err_ev_addr = mbus.mem_addr;
            state_d     = ST_RESP;
          end
        end
      end
      ST_ACCESS: begin
        if (ack) begin
          mem_rdata_d = sel_rdata;
          s_valid_d   = '0;
          mem_ready_d = 1'b1;
          state_d     = ST_RESP;
        end else if (tmo) begin
          mem_rdata_d = ERR_RDATA;
          s_valid_d   = '0;
          mem_ready_d = 1'b1;
          err_ev      = 1'b1;
          err_ev_code = 2'd2;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A clear coinciding with a new error still latches that error.
    err_irq_d  = err_irq_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    if (err_clr) begin
      err_irq_d  = 1'b0;
      err_code_d = 2'd0;
    end
    if (err_ev && (err_code_q == 2'd0 || err_clr)) begin
      err_irq_d  = 1'b1;
      err_code_d = err_ev_code;
      err_addr_d = err_ev_addr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      s_valid_q   <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_wstrb_q   <= '0;
      err_irq_q   <= 1'b0;
      err_addr_q  <= '0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      s_valid_q   <= s_valid_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_wstrb_q   <= s_wstrb_d;
      err_irq_q   <= err_irq_d;
      err_addr_q  <= err_addr_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mbus.mem_ready = mem_ready_q;
  assign mbus.mem_rdata = mem_rdata_q;
  assign sbus.s_valid   = s_valid_q;
  assign sbus.s_addr    = s_addr_q;
  assign sbus.s_wdata   = s_wdata_q;
  assign sbus.s_wstrb   = s_wstrb_q;
  assign err_irq        = err_irq_q;
  assign err_addr       = err_addr_q;
  assign err_code       = err_code_q;

endmodule

// File: tb/tb_picosoc_iomem_fabric.sv
// Bench for picosoc_iomem_fabric: directed vector table, hand sequences, then randomized traffic
// against a window/latency/error-latch reference model.
module tb_picosoc_iomem_fabric;
  localparam int          NS   = 4;
  localparam int          TMO  = 8;
  localparam logic [31:0] ERRD = 32'hBADB_ADDD;

  // Windows: s0 0x0300_0xxx, s1 0x0300_1xxx, s2 0x0300_xxxx (overlaps s0/s1), s3 0x02xx_xxxx
  logic [31:0] win_base [NS] = '{32'h0300_0000, 32'h0300_1000, 32'h0300_0000, 32'h0200_0000};
  logic [31:0] win_mask [NS] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFF00_0000};

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        err_clr = 1'b0;
  logic        err_irq;
  logic [31:0] err_addr;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  picosoc_iomem_fabric_if mbus ();
  picosoc_iomem_slv_if #(.NSLAVES(NS)) sbus ();

  picosoc_iomem_fabric #(
    .NSLAVES  (NS),
    .SLV_BASE ({32'h0200_0000, 32'h0300_0000, 32'h0300_1000, 32'h0300_0000}),
    .SLV_MASK ({32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000}),
    .TIMEOUT  (TMO),
    .ERR_RDATA(ERRD)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .mbus    (mbus),
    .sbus    (sbus),
    .err_irq (err_irq),
    .err_addr(err_addr),
    .err_code(err_code),
    .err_clr (err_clr)
  );

  // Peripheral models: ready after wait_cfg cycles of s_valid, data = slv_data ^ s_addr
  logic [31:0] slv_data [NS];
  int          wait_cfg [NS] = '{default: 0};
  bit          silent   [NS] = '{default: 1'b0};
  bit          spur     [NS] = '{default: 1'b0};
  int          scnt     [NS] = '{default: 0};
  int          wr_total = 0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  for (genvar gi = 0; gi < NS; gi++) begin : g_slv
    assign sbus.s_ready[gi] = (sbus.s_valid[gi] && !silent[gi] && scnt[gi] >= wait_cfg[gi]) || spur[gi];
    assign sbus.s_rdata[32*gi +: 32] = slv_data[gi] ^ sbus.s_addr;
    always @(posedge clk) scnt[gi] <= sbus.s_valid[gi] ? scnt[gi] + 1 : 0;
  end

  always @(posedge clk) begin
    if (|(sbus.s_valid & sbus.s_ready) && sbus.s_wstrb != 4'h0) begin
      wr_total   <= wr_total + 1;
      last_wdata <= sbus.s_wdata;
      last_wstrb <= sbus.s_wstrb;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int ref_slave(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & win_mask[i]) == (win_base[i] & win_mask[i])) return i;
    return -1;
  endfunction

  // Latency n = cycles after the sampling edge until mem_ready is seen (1 = T+1).
  task automatic do_xact(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                         input bit clr, output int lat, output logic [31:0] rdata,
                         output logic [3:0] sel1, output bit stable);
    lat = 0; rdata = 'x; sel1 = '0; stable = 1'b1;
    @(negedge clk);
    if (mbus.mem_ready) @(negedge clk);
    mbus.mem_valid = 1'b1; mbus.mem_addr = addr; mbus.mem_wdata = wdata; mbus.mem_wstrb = wstrb;
    err_clr = clr;
    @(posedge clk); #1;
    err_clr = 1'b0;
    mbus.mem_addr = ~addr; mbus.mem_wdata = ~wdata; mbus.mem_wstrb = ~wstrb;
    for (int n = 1; n <= 200; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      if (n == 1) sel1 = sbus.s_valid;
      if (sbus.s_addr !== addr || sbus.s_wdata !== wdata || sbus.s_wstrb !== wstrb) stable = 1'b0;
      if (mbus.mem_ready) begin lat = n; rdata = mbus.mem_rdata; break; end
    end
    mbus.mem_valid = 1'b0;
    $display("xact addr=%h wdata=%h wstrb=%h clr=%0d lat=%0d rdata=%h sel=%b err=%0d/%h",
             addr, wdata, wstrb, clr, lat, rdata, sel1, err_code, err_addr);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          wt;
    logic [3:0]  sel;
    int          lat;
    logic [31:0] rdata;
    logic [1:0]  code;
    logic [31:0] eaddr;
    int          tw;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          lat, seen, tgt, m_tw;
    logic [31:0] rd, a, wd;
    logic [3:0]  sel, ws;
    bit          st, clr, err;
    logic [1:0]  m_code, ecode;
    logic [31:0] m_eaddr;

    vecs[0] = '{32'h0300_1004, 32'h0,         4'h0, 0, 4'b0010, 2, 32'h1234_5678, 2'd0, 32'h0,         0};
    vecs[1] = '{32'h0300_0010, 32'h0000_00A5, 4'h1, 3, 4'b0001, 5, 32'h1300_0010, 2'd0, 32'h0,         1};
    vecs[2] = '{32'h0300_0020, 32'h0,         4'h0, 1, 4'b0001, 3, 32'h1300_0020, 2'd0, 32'h0,         1};
    vecs[3] = '{32'h0300_8000, 32'h0,         4'h0, 0, 4'b0100, 2, 32'h3300_8000, 2'd0, 32'h0,         1};
    vecs[4] = '{32'h02AB_CDEF, 32'h0,         4'h0, 2, 4'b1000, 4, 32'h42AB_CDEF, 2'd0, 32'h0,         1};
    vecs[5] = '{32'h0F00_0000, 32'h0,         4'h0, 0, 4'b0000, 1, ERRD,          2'd1, 32'h0F00_0000, 1};
    vecs[6] = '{32'h0F00_0004, 32'hFFFF_FFFF, 4'hF, 0, 4'b0000, 1, ERRD,          2'd1, 32'h0F00_0000, 1};

    slv_data = '{32'h1000_0000, 32'h1134_467C, 32'h3000_0000, 32'h4000_0000};
    mbus.mem_valid = 1'b0; mbus.mem_addr = '0; mbus.mem_wdata = '0; mbus.mem_wstrb = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_ready", mbus.mem_ready, 0);
    chk("rst_s_valid", sbus.s_valid, 0);
    chk("rst_err_irq", err_irq, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_mem_rdata", mbus.mem_rdata, 0);
    chk("rst_s_addr", sbus.s_addr, 0);
    chk("rst_err_addr", err_addr, 0);
    @(negedge clk); resetn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      for (int s = 0; s < NS; s++) wait_cfg[s] = vecs[i].wt;
      do_xact(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 1'b0, lat, rd, sel, st);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("vec%0d_sel", i), sel, vecs[i].sel);
      chk($sformatf("vec%0d_stable", i), st, 1);
      chk($sformatf("vec%0d_code", i), err_code, vecs[i].code);
      chk($sformatf("vec%0d_irq", i), err_irq, (vecs[i].code != 2'd0));
      if (vecs[i].code != 2'd0) chk($sformatf("vec%0d_eaddr", i), err_addr, vecs[i].eaddr);
      chk($sformatf("vec%0d_writes", i), wr_total, vecs[i].tw);
    end
    chk("write_data", last_wdata, 32'h0000_00A5);
    chk("write_strb", last_wstrb, 4'h1);
    for (int s = 0; s < NS; s++) wait_cfg[s] = 0;

    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    chk("clr_irq", err_irq, 0);
    chk("clr_code", err_code, 0);

    do_xact(32'h0F00_0100, 32'h0, 4'h0, 1'b0, lat, rd, sel, st);
    chk("err_a_addr", err_addr, 32'h0F00_0100);
    do_xact(32'h0F00_0200, 32'h0, 4'h0, 1'b1, lat, rd, sel, st);
    chk("clr_and_err_code", err_code, 2'd1);
    chk("clr_and_err_addr", err_addr, 32'h0F00_0200);
    chk("clr_and_err_irq", err_irq, 1);

`ifdef PICOSOC_FABRIC_TIMEOUT_EN
    silent[1] = 1'b1;
    do_xact(32'h0300_1008, 32'h0, 4'h0, 1'b1, lat, rd, sel, st);
    silent[1] = 1'b0;
    chk("tmo_lat", lat, TMO + 2);
    chk("tmo_rdata", rd, ERRD);
    chk("tmo_sel", sel, 4'b0010);
    chk("tmo_svalid_drop", sbus.s_valid, 0);
    chk("tmo_code", err_code, 2'd2);
    chk("tmo_eaddr", err_addr, 32'h0300_1008);
    do_xact(32'h0F00_0300, 32'h0, 4'h0, 1'b0, lat, rd, sel, st);
    chk("tmo_second_rdata", rd, ERRD);
    chk("tmo_second_code", err_code, 2'd2);
    chk("tmo_second_eaddr", err_addr, 32'h0300_1008);
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    chk("tmo_clr_irq", err_irq, 0);
`else
    silent[1] = 1'b1;
    @(negedge clk);
    mbus.mem_valid = 1'b1; mbus.mem_addr = 32'h0300_1008; mbus.mem_wstrb = 4'h0;
    @(posedge clk); #1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (mbus.mem_ready) seen++; end
    chk("notmo_no_ready", seen, 0);
    chk("notmo_svalid_held", sbus.s_valid, 4'b0010);
    silent[1] = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (mbus.mem_ready) begin lat = n; rd = mbus.mem_rdata; break; end
    end
    mbus.mem_valid = 1'b0;
    chk("notmo_late_lat", lat, 1);
    chk("notmo_rdata", rd, slv_data[1] ^ 32'h0300_1008);
    chk("notmo_code", err_code, 2'd1);
    $display("xact addr=03001008 held 40 cycles then acked lat=%0d", lat);
`endif

    silent[2] = 1'b1;
    @(negedge clk);
    mbus.mem_valid = 1'b1; mbus.mem_addr = 32'h0300_8000; mbus.mem_wstrb = 4'h0;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    @(negedge clk); resetn = 1'b0;
    #1;
    chk("rstmid_s_valid", sbus.s_valid, 0);
    chk("rstmid_mem_ready", mbus.mem_ready, 0);
    chk("rstmid_code", err_code, 0);
    chk("rstmid_s_addr", sbus.s_addr, 0);
    mbus.mem_valid = 1'b0;
    silent[2] = 1'b0;
    @(negedge clk); resetn = 1'b1;
    seen = 0;
    repeat (5) begin @(posedge clk); #1; if (mbus.mem_ready || sbus.s_valid != 0) seen++; end
    chk("rstmid_quiet", seen, 0);
    $display("xact addr=03008000 abandoned by reset");
    do_xact(32'h0300_8004, 32'h0, 4'h0, 1'b0, lat, rd, sel, st);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_rdata", rd, slv_data[2] ^ 32'h0300_8004);

    m_code = 2'd0; m_eaddr = '0; m_tw = wr_total;
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 5))
        0:       a = 32'h0300_0000 | $urandom_range(0, 32'hFFF);
        1:       a = 32'h0300_1000 | $urandom_range(0, 32'hFFF);
        2:       a = 32'h0300_2000 + $urandom_range(0, 32'hDFFF);
        3:       a = {8'h02, 24'($urandom)};
        4:       a = {8'h0F, 24'($urandom)};
        default: a = $urandom;
      endcase
      wd = $urandom;
      ws = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      clr = ($urandom_range(0, 3) == 0);
      tgt = ref_slave(a);
      for (int s = 0; s < NS; s++) begin
        slv_data[s] = $urandom;
        wait_cfg[s] = $urandom_range(0, 3);
        spur[s]     = (s != tgt) && ($urandom_range(0, 1) != 0);
        silent[s]   = 1'b0;
      end
`ifdef PICOSOC_FABRIC_TIMEOUT_EN
      if (tgt >= 0 && $urandom_range(0, 7) == 0) silent[tgt] = 1'b1;
`endif
      do_xact(a, wd, ws, clr, lat, rd, sel, st);

      if (clr) m_code = 2'd0;
      err = 1'b0; ecode = 2'd0;
      if (tgt < 0) begin
        err = 1'b1; ecode = 2'd1;
        chk("rnd_lat", lat, 1);
        chk("rnd_rdata", rd, ERRD);
        chk("rnd_sel", sel, 0);
      end else if (silent[tgt]) begin
        err = 1'b1; ecode = 2'd2;
        chk("rnd_lat", lat, TMO + 2);
        chk("rnd_rdata", rd, ERRD);
        chk("rnd_sel", sel, 32'd1 << tgt);
      end else begin
        if (ws != 4'h0) m_tw++;
        chk("rnd_lat", lat, 2 + wait_cfg[tgt]);
        chk("rnd_rdata", rd, slv_data[tgt] ^ a);
        chk("rnd_sel", sel, 32'd1 << tgt);
      end
      if (err && m_code == 2'd0) begin m_code = ecode; m_eaddr = a; end
      chk("rnd_stable", st, 1);
      chk("rnd_code", err_code, m_code);
      chk("rnd_irq", err_irq, (m_code != 2'd0));
      if (m_code != 2'd0) chk("rnd_eaddr", err_addr, m_eaddr);
      chk("rnd_writes", wr_total, m_tw);
    end
    for (int s = 0; s < NS; s++) begin spur[s] = 1'b0; silent[s] = 1'b0; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/picosoc_iomem_fabric.md
# picosoc_iomem_fabric

Parametrised iomem interconnect between the picorv32 native memory port and up to eight memory-mapped peripherals. It replaces the flat single-window `iomem_*` decode of the SoC top with per-slave address windows and registered slave handshakes. Unmapped-address and timeout errors are reported, and the first error is captured with an interrupt. It sits between the CPU/SoC bus and the on-board peripherals (codec, GPIO, timers).

## Interface
- `NSLAVES`, 4: number of slave ports, 1..8.
- `SLV_BASE`, {NSLAVES{32'h0300_0000}}: packed `NSLAVES*32` base addresses; slave i uses `[32*i+31:32*i]`.
- `SLV_MASK`, {NSLAVES{32'hFFFF_0000}}: packed `NSLAVES*32` masks; slave i hits when `(addr & mask_i) == (base_i & mask_i)`.
- `TIMEOUT`, 255: cycles in ACCESS before a timeout error, 1..65535.
- `ERR_RDATA`, 32'hBADB_ADDD: read data returned on any error response.
- `clk` in 1: clock.
- `resetn` in 1: asynchronous active-low reset.
- `mem_valid` in 1: master request.
- `mem_ready` out 1: master response strobe.
- `mem_addr` in 32: master address.
- `mem_wdata` in 32: master write data.
- `mem_wstrb` in 4: byte write strobes; 0 means read.
- `mem_rdata` out 32: registered read data.
- `s_valid` out NSLAVES: one-hot slave request.
- `s_ready` in NSLAVES: slave acknowledge.
- `s_addr` out 32: registered address, shared by all slaves.
- `s_wdata` out 32: registered write data, shared by all slaves.
- `s_wstrb` out 4: registered strobes, shared by all slaves.
- `s_rdata` in NSLAVES*32: packed slave read data.
- `err_irq` out 1: high while an error is latched.
- `err_addr` out 32: address of the first unacknowledged error.
- `err_code` out 2: 0 none, 1 unmapped, 2 timeout.
- `err_clr` in 1: clears the latched error (single-cycle pulse).

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Reset (async, `resetn` low): state IDLE; `mem_ready`, `s_valid`, `err_irq`, `err_code` = 0; `mem_rdata`, `s_addr`, `s_wdata`, `s_wstrb`, `err_addr` = 0; timeout counter = 0. This applies mid-transaction as well; an outstanding slave request is abandoned.
- IDLE with `mem_valid` high and `mem_ready` low:
  - Decode using a priority encoder. The lowest-index matching slave wins on overlapping windows.
  - Register `s_addr`, `s_wdata` and `s_wstrb`.
  - On a hit, set `s_valid[i]` and go to ACCESS.
  - On a miss, go to RESP with error unmapped.
- ACCESS:
  - `s_valid[i]` is held and the counter increments each cycle.
  - On `s_ready[i]`: capture `s_rdata[i]` into `mem_rdata`, drop `s_valid`, go to RESP.
  - If the counter reaches `TIMEOUT` without `s_ready[i]`: drop `s_valid`, load `ERR_RDATA`, go to RESP with error timeout.
  - `s_ready` on non-selected slaves is ignored.
- RESP: `mem_ready` is high for exactly one cycle, then the FSM returns to IDLE and clears the counter.
- Error latch:
  - On an error when `err_code` == 0: load `err_addr`/`err_code` and set `err_irq`.
  - Later errors while latched still complete with `ERR_RDATA` but do not overwrite the latch.
  - `err_clr` clears the latch. If `err_clr` and a new error occur in the same cycle, the new error is latched.
- Writes to unmapped or timed-out slaves have no side effects.

## Timing
- Master request at cycle T (sampled in IDLE):
  - `s_valid` high at T+1.
  - A zero-wait slave asserts `s_ready` at T+1.
  - `mem_ready` at T+2 (minimum latency 2).
  - Each slave wait state adds one cycle.
- Unmapped access: `mem_ready` at T+1.
- Timeout: `mem_ready` at T+1+`TIMEOUT`+1.
- `s_valid` drops in the cycle after acknowledge or timeout; slaves must tolerate withdrawal without `s_ready`. A late `s_ready` is ignored.
- Back-to-back: the next request can be sampled in IDLE one cycle after the `mem_ready` pulse.
- `mem_rdata` is valid only while `mem_ready` is high; it holds its last value otherwise.
- `err_irq` rises in the same cycle as the error's `mem_ready`.

## Configuration
- `PICOSOC_FABRIC_TIMEOUT_EN` defined: the timeout counter and the timeout error path are built.
- Not defined:
  - ACCESS waits indefinitely for `s_ready`.
  - The counter is removed; `err_code` 2 never occurs.
  - Unmapped detection remains.

## Test plan
- NSLAVES=4, slave 1 window 0x0300_1000/0xFFFF_F000 with zero wait. Read 0x0300_1004 returning 0x1234_5678 -> `s_valid`=4'b0010 at T+1, `mem_ready` at T+2, `mem_rdata`=0x1234_5678.
- Write 0xA5 with `wstrb`=4'b0001 to slave 0 with 3 wait states -> `s_wdata`/`s_wstrb` stable during ACCESS, `mem_ready` at T+5.
- Read of unmapped 0x0F00_0000 -> `mem_ready` at T+1, `mem_rdata`=0xBADB_ADDD, `err_code`=1, `err_addr`=0x0F00_0000, `err_irq`=1.
- TIMEOUT=8 with a silent slave, macro defined -> `s_valid` dropped after 8 cycles, `mem_ready` at T+10, `err_code`=2. A second error keeps `err_addr`; after `err_clr`, `err_irq`=0.
- Windows for slaves 0 and 2 overlap -> slave 0 selected.
- `resetn` pulsed low during ACCESS -> `s_valid`=0 immediately, FSM in IDLE, no `mem_ready` pulse.
